aes_frame_loader: RTL and testbench

- Byte-stream front end that sits directly upstream of the 33-byte register bank feeding the AES core. The bank holds byte 0 as the mode/opcode, bytes 1-16 as the key and bytes 17-32 as the data.
- Accepts framed bytes over a valid/ready handshake and checks the frame format and XOR checksum.
- Generates the byte-addressed write strobes for the bank.
- Signals the core when a complete, good frame is loaded, and holds off new input until the core acknowledges.

---
 rtl/aes_frame_loader_if.sv | 23 ++
 rtl/aes_frame_loader.sv | 155 +++++++++++++++
 tb/tb_aes_frame_loader.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_frame_loader_if.sv
// Byte-stream, register-bank write and frame handshake signals of the AES frame loader.
// The loader connects through the slave modport; the stream source and AES core use master.
interface aes_frame_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] wr_data;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic       frame_valid;
    logic       frame_ack;
    logic       frame_err;

    modport master (
        output byte_in, byte_valid, frame_ack,
        input  byte_ready, wr_data, wr_en, wr_addr, frame_valid, frame_err
    );

    modport slave (
        input  byte_in, byte_valid, frame_ack,
        output byte_ready, wr_data, wr_en, wr_addr, frame_valid, frame_err
    );
endinterface

// File: rtl/aes_frame_loader.sv
// Frame loader for the AES register bank: hunts for SOF, writes the payload bytes to the
// bank, verifies the XOR checksum and holds the frame until the core acknowledges it.
module aes_frame_loader #(
    parameter int         NUM_BYTES = 33,
    parameter logic [7:0] SOF_BYTE  = 8'hA5,
    parameter int         TIMEOUT   = 1023
) (
    input logic               clk,
    input logic               rst,
    aes_frame_loader_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [5:0] LAST_IDX = 6'(NUM_BYTES - 1);
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    function automatic logic [7:0] csum_next(input logic [7:0] sum, input logic [7:0] data);
        return sum ^ data;
    endfunction

    logic [1:0] state_r,       state_s;
    logic [5:0] byte_cnt_r,    byte_cnt_s;
    logic [7:0] csum_r,        csum_s;
    logic [9:0] tmo_cnt_r,     tmo_cnt_s;
    logic       byte_ready_r,  byte_ready_s;
    logic       wr_en_r,       wr_en_s;
    logic [5:0] wr_addr_r,     wr_addr_s;
    logic [7:0] wr_data_r,     wr_data_s;
    logic       frame_valid_r, frame_valid_s;
    logic       frame_err_r,   frame_err_s;
    logic       accept_s;
    logic       tmo_hit_s;

    assign accept_s  = bus.byte_valid & byte_ready_r;
    // The idle gap expires on the edge that would bring the counter to TIMEOUT.
    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

    // Next-state, checksum, counter and bank-write decode.
    always_comb begin
        state_s       = state_r;
        byte_cnt_s    = byte_cnt_r;
        csum_s        = csum_r;
        tmo_cnt_s     = tmo_cnt_r;
        wr_en_s       = 1'b0;
        wr_addr_s     = wr_addr_r;
        wr_data_s     = wr_data_r;
        frame_valid_s = frame_valid_r;
        frame_err_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (accept_s && (bus.byte_in == SOF_BYTE)) begin
                    state_s    = ST_LOAD;
                    byte_cnt_s = 6'd0;
                    csum_s     = 8'd0;
                    tmo_cnt_s  = 10'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    wr_en_s    = 1'b1;
                    wr_addr_s  = byte_cnt_r;
                    wr_data_s  = bus.byte_in;
                    csum_s     = csum_next(csum_r, bus.byte_in);
                    byte_cnt_s = byte_cnt_r + 6'd1;
                    tmo_cnt_s  = 10'd0;
                    if (byte_cnt_r == LAST_IDX) begin
                        state_s = ST_CHECK;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else if (tmo_hit_s) begin
                    frame_err_s = 1'b1;
                    tmo_cnt_s   = 10'd0;
                    state_s     = ST_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 10'd1;
                end
            end
            ST_CHECK: begin
                if (accept_s) begin
                    tmo_cnt_s = 10'd0;
                    if (bus.byte_in == csum_r) begin
                        frame_valid_s = 1'b1;
                        state_s       = ST_HOLD;
                    end else begin
                        frame_err_s = 1'b1;
                        state_s     = ST_IDLE;
                    end
                end else if (tmo_hit_s) begin
                    frame_err_s = 1'b1;
                    tmo_cnt_s   = 10'd0;
                    state_s     = ST_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 10'd1;
                end
            end
            ST_HOLD: begin
                if (bus.frame_ack) begin
                    frame_valid_s = 1'b0;
                    state_s       = ST_IDLE;
                end else begin
                    frame_valid_s = 1'b1;
                end
            end
            default: begin
                state_s       = ST_IDLE;
                frame_valid_s = 1'b0;
            end
        endcase

        byte_ready_s = (state_s != ST_HOLD);
    end

    // State and output registers; reset also drops any bank write in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            byte_cnt_r    <= 6'd0;
            csum_r        <= 8'd0;
            tmo_cnt_r     <= 10'd0;
            byte_ready_r  <= 1'b0;
            wr_en_r       <= 1'b0;
            wr_addr_r     <= 6'd0;
            wr_data_r     <= 8'd0;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            byte_cnt_r    <= byte_cnt_s;
            csum_r        <= csum_s;
            tmo_cnt_r     <= tmo_cnt_s;
            byte_ready_r  <= byte_ready_s;
            wr_en_r       <= wr_en_s;
            wr_addr_r     <= wr_addr_s;
            wr_data_r     <= wr_data_s;
            frame_valid_r <= frame_valid_s;
            frame_err_r   <= frame_err_s;
        end
    end

    assign bus.byte_ready  = byte_ready_r;
    assign bus.wr_en       = wr_en_r;
    assign bus.wr_addr     = wr_addr_r;
    assign bus.wr_data     = wr_data_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.frame_err   = frame_err_r;

endmodule

// File: tb/tb_aes_frame_loader.sv
// Directed bench for aes_frame_loader: a frame-level reference model compared every cycle,
// plus hand-computed expectations for each scenario.
`timescale 1ns/1ps
module tb_aes_frame_loader;

    localparam int TIMEOUT = 1023;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aes_frame_loader_if bus();

    aes_frame_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    logic [5:0] wl_addr[$];
    logic [7:0] wl_data[$];
    logic [7:0] pl  [33];
    logic [7:0] pl2 [33];

    // pos: -1 hunting for SOF, 0..32 next payload index, 33 awaiting checksum, 34 holding
    typedef struct packed {
        int         pos;
        int         idle;
        logic [7:0] sum;
        logic       ready;
        logic       wr_en;
        logic [5:0] addr;
        logic [7:0] data;
        logic       fv;
        logic       err;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t model_reset();
        mdl_t r;
        r = '0;
        r.pos = -1;
        return r;
    endfunction

    function automatic mdl_t model_step(input mdl_t c, input logic v, input logic [7:0] b,
                                        input logic ack);
        mdl_t n;
        bit   acc;
        n     = c;
        acc   = v && c.ready;
        n.wr_en = 1'b0;
        n.err   = 1'b0;
        if (c.pos == 34) begin
            if (ack) begin
                n.pos = -1;
                n.fv  = 1'b0;
            end
        end else if (c.pos == -1) begin
            if (acc && b == 8'hA5) begin
                n.pos  = 0;
                n.sum  = 8'h00;
                n.idle = 0;
            end
        end else if (acc) begin
            n.idle = 0;
            if (c.pos < 33) begin
                n.wr_en = 1'b1;
                n.addr  = 6'(c.pos);
                n.data  = b;
                n.sum   = c.sum ^ b;
                n.pos   = c.pos + 1;
            end else if (b == c.sum) begin
                n.fv  = 1'b1;
                n.pos = 34;
            end else begin
                n.err = 1'b1;
                n.pos = -1;
            end
        end else if (c.idle + 1 >= TIMEOUT) begin
            n.err  = 1'b1;
            n.pos  = -1;
            n.idle = 0;
        end else begin
            n.idle = c.idle + 1;
        end
        n.ready = (n.pos != 34);
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model advances on the same edges as the DUT.
    always @(posedge clk or negedge rst) begin
        if (!rst) m <= model_reset();
        else      m <= model_step(m, bus.byte_valid, bus.byte_in, bus.frame_ack);
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cycle_model",
                32'({bus.byte_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_valid, bus.frame_err}),
                32'({m.ready, m.wr_en, m.addr, m.data, m.fv, m.err}));
        end
    end

    // Log of bank writes observed on the write port.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wl_addr.push_back(bus.wr_addr);
            wl_data.push_back(bus.wr_data);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int   n;
        rdy = 1'b0;
        n   = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!rdy && n < 2000) begin
            @(negedge clk);
            rdy = bus.byte_ready;
            @(posedge clk);
            n++;
        end
        #1;
        bus.byte_valid = 1'b0;
        if (!rdy) chk("accept_wait", 32'd0, 32'd1);
    endtask

    task automatic gap(input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] p [33], input logic [7:0] csum, input int max_gap);
        send_byte(8'hA5);
        for (int i = 0; i < 33; i++) begin
            gap(max_gap);
            send_byte(p[i]);
        end
        gap(max_gap);
        send_byte(csum);
    endtask

    task automatic do_ack();
        bus.frame_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_ack = 1'b0;
        chk("ack_release", 32'({bus.frame_valid, bus.byte_ready}), 32'b01);
    endtask

    function automatic int contig_errors();
        int bad;
        bad = 0;
        foreach (wl_addr[i]) begin
            if (wl_addr[i] !== 6'(i) || wl_data[i] !== 8'(i)) bad++;
        end
        return bad;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the summary by %0t", $time);
        $fatal(1);
    end

    initial begin
        int   n;
        bit   seen;
        logic rdy_seen;

        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        bus.frame_ack  = 1'b0;
        for (int i = 0; i < 33; i++) begin
            pl[i]  = 8'(i);
            pl2[i] = (i == 5) ? 8'hA5 : 8'(i);
        end

        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("reset_outputs",
            32'({bus.byte_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_valid, bus.frame_err}),
            32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_before_edge", 32'(bus.byte_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", 32'(bus.byte_ready), 32'd1);

        // Good frame, back-to-back
        wl_addr.delete(); wl_data.delete();
        send_frame(pl, 8'h20, 0);
        chk("good_valid_ready", 32'({bus.frame_valid, bus.byte_ready}), 32'b10);
        chk("good_wr_count", 32'(wl_addr.size()), 32'd33);
        chk("good_addr_data", 32'(contig_errors()), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("good_hold", 32'({bus.frame_valid, bus.byte_ready}), 32'b10);
        do_ack();

        // Bad checksum, then recovery
        wl_addr.delete(); wl_data.delete();
        send_frame(pl, 8'h21, 0);
        chk("bad_err_pulse", 32'({bus.frame_err, bus.frame_valid}), 32'b10);
        @(posedge clk);
        #1;
        chk("bad_err_one_cycle", 32'({bus.frame_err, bus.frame_valid, bus.byte_ready}), 32'b001);
        wl_addr.delete(); wl_data.delete();
        send_frame(pl, 8'h20, 0);
        chk("recover_valid", 32'(bus.frame_valid), 32'd1);
        chk("recover_wr_count", 32'(wl_addr.size()), 32'd33);
        do_ack();

        // Idle noise, then SOF value inside the payload
        wl_addr.delete(); wl_data.delete();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        repeat (2) @(posedge clk);
        #1;
        chk("noise_no_write", 32'(wl_addr.size()), 32'd0);
        send_frame(pl2, 8'h80, 0);
        chk("sof_payload_valid", 32'(bus.frame_valid), 32'd1);
        chk("sof_payload_addr5", 32'({wl_addr[5], wl_data[5]}), 32'({6'd5, 8'hA5}));
        do_ack();

        // Timeout after 10 payload bytes
        wl_addr.delete(); wl_data.delete();
        send_byte(8'hA5);
        for (int i = 0; i < 10; i++) send_byte(pl[i]);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 1100) begin
            @(negedge clk);
            n++;
            seen = (bus.frame_err === 1'b1);
        end
        chk("timeout_cycle", 32'(n), 32'd1024);
        chk("timeout_writes", 32'({26'(wl_addr.size()), wl_addr[9]}), 32'({26'd10, 6'd9}));
        @(posedge clk);
        #1;
        send_byte(8'h3C);
        repeat (3) @(posedge clk);
        #1;
        chk("timeout_idle_ignore", 32'(wl_addr.size()), 32'd10);

        // Random backpressure, then stalled input while holding
        wl_addr.delete(); wl_data.delete();
        send_frame(pl, 8'h20, 3);
        chk("bp_valid", 32'(bus.frame_valid), 32'd1);
        chk("bp_contiguous", 32'({26'(wl_addr.size()), 6'(contig_errors())}), 32'({26'd33, 6'd0}));
        bus.byte_in    = 8'h55;
        bus.byte_valid = 1'b1;
        rdy_seen       = 1'b0;
        repeat (20) begin
            @(negedge clk);
            rdy_seen = rdy_seen | bus.byte_ready;
        end
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        chk("hold_no_accept", 32'({rdy_seen, 7'(wl_addr.size())}), 32'({1'b0, 7'd33}));
        do_ack();

        // Asynchronous reset at payload byte 15
        wl_addr.delete(); wl_data.delete();
        send_byte(8'hA5);
        for (int i = 0; i < 16; i++) send_byte(pl[i]);
        chk("pre_reset_wr", 32'({bus.wr_en, bus.wr_addr}), 32'({1'b1, 6'd15}));
        #1;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs",
            32'({bus.byte_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_valid, bus.frame_err}),
            32'd0);
        chk("async_reset_dropped_wr", 32'(wl_addr.size()), 32'd15);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        wl_addr.delete(); wl_data.delete();
        send_frame(pl, 8'h20, 0);
        chk("post_reset_valid", 32'(bus.frame_valid), 32'd1);
        chk("post_reset_frame", 32'({26'(wl_addr.size()), 6'(contig_errors())}), 32'({26'd33, 6'd0}));
        do_ack();

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
